// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: soft-start duty sequencer in front of the PWM core.
// Define PWM_SOFT_STOP_EN to ramp duty down on stop instead of cutting it.
module pwm_ramp_controller #(
  parameter int WORD_LENGTH = 8,
  parameter int FREQ_LENGTH = 2,
  parameter int STEP        = 1,
  parameter int TICK_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [WORD_LENGTH-1:0] cmd_duty,
  input  logic [FREQ_LENGTH-1:0] cmd_freq,
  input  logic                   stop_req,
  output logic                   pwm_start,
  output logic [WORD_LENGTH-1:0] pwm_duty,
  output logic [FREQ_LENGTH-1:0] pwm_freq,
  output logic                   busy,
  output logic                   done
);

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [WORD_LENGTH-1:0] STEP_W = WORD_LENGTH'(STEP);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP      = 3'd1,
    HOLD      = 3'd2,
`ifdef PWM_SOFT_STOP_EN
    RAMP_DOWN = 3'd3,
    STOPPING  = 3'd4
`else
    RAMP_DOWN = 3'd3
`endif
  } state_t;

  state_t state, state_nx;
  logic start_nx, done_nx;
  logic [WORD_LENGTH-1:0] duty_nx, tgt, tgt_nx;
  logic [FREQ_LENGTH-1:0] freq_nx, pend, pend_nx;
  logic [TW-1:0] tick, tick_nx;
  logic tick_end, accept, stop_hit;

  // One ramp step toward goal, clamped so it never overshoots.
  function automatic logic [WORD_LENGTH-1:0] step_toward(
    input logic [WORD_LENGTH-1:0] cur,
    input logic [WORD_LENGTH-1:0] goal
  );
    logic [WORD_LENGTH-1:0] r;
    if (goal >= cur)
      r = (goal - cur <= STEP_W) ? goal : cur + STEP_W;
    else
      r = (cur - goal <= STEP_W) ? goal : cur - STEP_W;
    return r;
  endfunction

  assign cmd_ready = ((state == IDLE) | (state == HOLD)) & ~stop_req;
  assign accept = cmd_valid & cmd_ready;
  assign tick_end = (tick == TICK_LAST);
  assign stop_hit = stop_req &
    ((state == RAMP) | (state == HOLD) | (state == RAMP_DOWN));

`ifdef PWM_SOFT_STOP_EN
  assign busy = (state == RAMP) | (state == RAMP_DOWN) |
                (state == STOPPING);
`else
  assign busy = (state == RAMP) | (state == RAMP_DOWN);
`endif

  // Next-state and next-output decode; tick restarts on every state entry.
  always_comb begin
    state_nx = state;
    start_nx = pwm_start;
    duty_nx  = pwm_duty;
    freq_nx  = pwm_freq;
    tgt_nx   = tgt;
    pend_nx  = pend;
    done_nx  = 1'b0;
    tick_nx  = '0;
    if (stop_hit) begin
`ifdef PWM_SOFT_STOP_EN
      state_nx = STOPPING;
`else
      state_nx = IDLE;
      start_nx = 1'b0;
      duty_nx  = '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            freq_nx  = cmd_freq;
            tgt_nx   = cmd_duty;
            start_nx = 1'b1;
            duty_nx  = '0;
            if (cmd_duty == '0) begin
              state_nx = HOLD;
              done_nx  = 1'b1;
            end else begin
              state_nx = RAMP;
            end
          end
        end
        RAMP: begin
          if (tick_end) begin
            duty_nx = step_toward(pwm_duty, tgt);
            if (duty_nx == tgt) begin
              state_nx = HOLD;
              done_nx  = 1'b1;
            end
          end else begin
            tick_nx = tick + TICK_ONE;
          end
        end
        HOLD: begin
          if (accept) begin
            tgt_nx = cmd_duty;
            if (cmd_freq != pwm_freq) begin
              pend_nx  = cmd_freq;
              state_nx = RAMP_DOWN;
            end else if (cmd_duty == pwm_duty) begin
              done_nx = 1'b1;
            end else begin
              state_nx = RAMP;
            end
          end
        end
        RAMP_DOWN: begin
          if (tick_end) duty_nx = step_toward(pwm_duty, '0);
          else tick_nx = tick + TICK_ONE;
          if ((pwm_duty == '0) | (duty_nx == '0)) begin
            duty_nx = '0;
            tick_nx = '0;
            freq_nx = pend;
            if (tgt == '0) begin
              state_nx = HOLD;
              done_nx  = 1'b1;
            end else begin
              state_nx = RAMP;
            end
          end
        end
`ifdef PWM_SOFT_STOP_EN
        STOPPING: begin
          if (pwm_duty == '0) begin
            state_nx = IDLE;
            start_nx = 1'b0;
          end else if (tick_end) begin
            duty_nx = step_toward(pwm_duty, '0);
          end else begin
            tick_nx = tick + TICK_ONE;
          end
        end
`endif
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pwm_start <= 1'b0;
      pwm_duty  <= '0;
      pwm_freq  <= '0;
      done      <= 1'b0;
      tick      <= '0;
      tgt       <= '0;
      pend      <= '0;
    end else begin
      state     <= state_nx;
      pwm_start <= start_nx;
      pwm_duty  <= duty_nx;
      pwm_freq  <= freq_nx;
      done      <= done_nx;
      tick      <= tick_nx;
      tgt       <= tgt_nx;
      pend      <= pend_nx;
    end
  end

endmodule
